// File: rtl/matched_pixel_writer.sv
// Packs 12-bit matcher pixels into DRAM application words and issues sequential
// single-word MIG writes with a wrapping address; supports end-of-frame flush.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_FILL      | round-robin draining of matcher ports into the slot buffer
// S_WRITE     | command and write data presented to the MIG until accepted
// S_FLUSH_ACK | one-cycle flush_done pulse, flush latch cleared
module matched_pixel_writer #(
  parameter int                    N_MATCHER      = 4,
  parameter int                    ADDR_WIDTH     = 27,
  parameter int                    APP_DATA_WIDTH = 256,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR     = 27'h000_0000,
  parameter logic [ADDR_WIDTH-1:0] END_ADDR       = 27'h3ff_fff8,
  parameter int                    ADDR_INC       = 8
) (
  input  logic                        dram_clk,
  input  logic                        reset_n,
  input  logic [N_MATCHER-1:0]        pixel_pending,
  input  logic [12*N_MATCHER-1:0]     pixel,
  output logic [N_MATCHER-1:0]        pixel_ack,
  input  logic                        flush,
  output logic                        flush_done,
  input  logic                        app_rdy,
  output logic                        app_en,
  output logic [2:0]                  app_cmd,
  output logic [ADDR_WIDTH-1:0]       app_addr,
  input  logic                        app_wdf_rdy,
  output logic                        app_wdf_wren,
  output logic [APP_DATA_WIDTH-1:0]   app_wdf_data,
  output logic [31:0]                 words_written,
  output logic                        wrapped
);

  localparam int SLOTS = APP_DATA_WIDTH / 16;
  localparam int CNT_W = $clog2(SLOTS + 1);
  localparam int RR_W  = (N_MATCHER > 1) ? $clog2(N_MATCHER) : 1;

  typedef enum logic [1:0] {
    S_FILL,
    S_WRITE,
    S_FLUSH_ACK
  } state_t;

  state_t                    state;
  state_t                    state_nxt;
  logic [CNT_W-1:0]          count;
  logic [CNT_W-1:0]          count_nxt;
  logic [RR_W-1:0]           rr;
  logic [RR_W-1:0]           rr_nxt;
  logic [RR_W-1:0]           grant;
  logic                      grant_valid;
  logic                      take;
  logic [APP_DATA_WIDTH-1:0] slots;
  logic [APP_DATA_WIDTH-1:0] slots_nxt;
  logic                      flush_lat;
  logic                      flush_active;
  logic                      flush_write;
  logic                      word_ready;
  logic                      wr_done;

  assign app_cmd = 3'b000;

  // First pending port at or after the round-robin pointer.
  always_comb begin
    grant_valid = 1'b0;
    grant       = '0;
    for (int k = 0; k < N_MATCHER; k++) begin
      if (!grant_valid && pixel_pending[(int'(rr) + k) % N_MATCHER]) begin
        grant_valid = 1'b1;
        grant       = RR_W'((int'(rr) + k) % N_MATCHER);
      end
    end
  end

  assign take      = (state == S_FILL) && (count < CNT_W'(SLOTS)) && grant_valid;
  assign pixel_ack = take ? (N_MATCHER'(1) << grant) : '0;
  assign rr_nxt    = (grant == RR_W'(N_MATCHER - 1)) ? '0 : grant + RR_W'(1);
  assign count_nxt = count + CNT_W'(take);

  always_comb begin
    slots_nxt = slots;
    if (take) begin
      slots_nxt[16*int'(count) +: 16] = {4'h0, pixel[12*int'(grant) +: 12]};
    end
  end

  // The grant of this cycle counts toward the word, so a flush coinciding
  // with a grant carries that pixel out in the flushed word.
  assign flush_active = flush | flush_lat;
  assign word_ready   = (count_nxt == CNT_W'(SLOTS)) ||
                        (flush_active && (count_nxt != '0));
  assign wr_done      = (state == S_WRITE) &&
                        (!app_en || app_rdy) && (!app_wdf_wren || app_wdf_rdy);

  always_comb begin
    state_nxt = state;
    case (state)
      S_FILL: begin
        if (word_ready) begin
          state_nxt = S_WRITE;
        end else if (flush_active) begin
          state_nxt = S_FLUSH_ACK;
        end
      end
      S_WRITE: begin
        if (wr_done) begin
          state_nxt = flush_write ? S_FLUSH_ACK : S_FILL;
        end
      end
      S_FLUSH_ACK: state_nxt = S_FILL;
      default:     state_nxt = S_FILL;
    endcase
  end

  always_ff @(posedge dram_clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_FILL;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge dram_clk or negedge reset_n) begin
    if (!reset_n) begin
      count         <= '0;
      rr            <= '0;
      slots         <= '0;
      flush_lat     <= 1'b0;
      flush_write   <= 1'b0;
      flush_done    <= 1'b0;
      app_en        <= 1'b0;
      app_wdf_wren  <= 1'b0;
      app_wdf_data  <= '0;
      app_addr      <= START_ADDR;
      words_written <= '0;
      wrapped       <= 1'b0;
    end else begin
      flush_done <= (state_nxt == S_FLUSH_ACK);

      // A new flush request wins over the clear in S_FLUSH_ACK so it is not lost.
      if (flush) begin
        flush_lat <= 1'b1;
      end else if (state == S_FLUSH_ACK) begin
        flush_lat <= 1'b0;
      end

      case (state)
        S_FILL: begin
          slots <= slots_nxt;
          count <= count_nxt;
          if (take) begin
            rr <= rr_nxt;
          end
          if (word_ready) begin
            app_en       <= 1'b1;
            app_wdf_wren <= 1'b1;
            app_wdf_data <= slots_nxt;
            flush_write  <= flush_active;
          end
        end
        S_WRITE: begin
          if (app_rdy) begin
            app_en <= 1'b0;
          end
          if (app_wdf_rdy) begin
            app_wdf_wren <= 1'b0;
          end
          if (wr_done) begin
            words_written <= words_written + 32'd1;
            count         <= '0;
            slots         <= '0;
            if (app_addr == END_ADDR) begin
              app_addr <= START_ADDR;
              wrapped  <= 1'b1;
            end else begin
              app_addr <= app_addr + ADDR_WIDTH'(ADDR_INC);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_matched_pixel_writer.sv
// Scoreboard bench for matched_pixel_writer: a matcher FWFT model feeds the DUT,
// a reference model predicts acks, written words, addresses and flush_done.
module tb_matched_pixel_writer;

  localparam int N     = 4;
  localparam int AW    = 27;
  localparam int DW    = 256;
  localparam int SLOTS = DW / 16;
  localparam logic [AW-1:0] END_A = 27'h20;

  localparam int M_FILL  = 0;
  localparam int M_WRITE = 1;
  localparam int M_FACK  = 2;

  logic            dram_clk = 1'b0;
  logic            reset_n;
  logic [N-1:0]    pixel_pending;
  logic [12*N-1:0] pixel;
  logic [N-1:0]    pixel_ack;
  logic            flush;
  logic            flush_done;
  logic            app_rdy;
  logic            app_en;
  logic [2:0]      app_cmd;
  logic [AW-1:0]   app_addr;
  logic            app_wdf_rdy;
  logic            app_wdf_wren;
  logic [DW-1:0]   app_wdf_data;
  logic [31:0]     words_written;
  logic            wrapped;

  matched_pixel_writer #(
    .N_MATCHER(N), .ADDR_WIDTH(AW), .APP_DATA_WIDTH(DW),
    .START_ADDR(27'h0), .END_ADDR(END_A), .ADDR_INC(8)
  ) dut (
    .dram_clk(dram_clk), .reset_n(reset_n),
    .pixel_pending(pixel_pending), .pixel(pixel), .pixel_ack(pixel_ack),
    .flush(flush), .flush_done(flush_done),
    .app_rdy(app_rdy), .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr),
    .app_wdf_rdy(app_wdf_rdy), .app_wdf_wren(app_wdf_wren), .app_wdf_data(app_wdf_data),
    .words_written(words_written), .wrapped(wrapped)
  );

  always #5 dram_clk = ~dram_clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          fl;
  } exp_t;

  exp_t        sbq[$];
  logic [11:0] mq[N][$];
  int          pop_g = -1;

  int n_chk = 0;
  int n_err = 0;

  int            mst, mcount, mrr, prev, g;
  int unsigned   mwords;
  logic [AW-1:0] maddr;
  logic          mwrapped, m_en, m_wren, mlat, fa;
  logic [DW-1:0] mdata;
  logic [N-1:0]  exp_ack;
  exp_t          e;

  int            n_ack, en_cycles, wren_cycles, fd_cnt;
  logic [DW-1:0] last_wdata;
  logic [AW-1:0] last_waddr;

  task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Matcher FWFT ports: pops from the previous edge applied, then heads presented.
  always begin
    @(negedge dram_clk);
    #1;
    if (pop_g >= 0 && mq[pop_g].size() > 0) void'(mq[pop_g].pop_front());
    pop_g = -1;
    for (int i = 0; i < N; i++) begin
      pixel_pending[i]   = (mq[i].size() > 0);
      pixel[12*i +: 12]  = (mq[i].size() > 0) ? mq[i][0] : 12'h0;
    end
  end

  // Reference model, evaluated just before each rising edge.
  always begin
    @(negedge dram_clk);
    #4;
    if (!reset_n) begin
      mst = M_FILL; mcount = 0; mrr = 0; maddr = '0; mwords = 0; mwrapped = 1'b0;
      m_en = 1'b0; m_wren = 1'b0; mlat = 1'b0; mdata = '0;
      sbq.delete();
    end else begin
      if (app_en) en_cycles++;
      if (app_wdf_wren) wren_cycles++;
      if (flush_done) fd_cnt++;
      chk("addr", app_addr, maddr);
      chk("words_written", words_written, mwords);
      chk("wrapped", wrapped, mwrapped);
      chk("app_en", app_en, m_en);
      chk("app_wdf_wren", app_wdf_wren, m_wren);
      chk("flush_done", flush_done, mst == M_FACK);
      prev    = mst;
      fa      = flush | mlat;
      exp_ack = '0;
      case (mst)
        M_FILL: begin
          g = -1;
          if (mcount < SLOTS) begin
            for (int k = 0; k < N; k++) begin
              if (g < 0 && pixel_pending[(mrr + k) % N]) g = (mrr + k) % N;
            end
          end
          if (g >= 0) exp_ack[g] = 1'b1;
          chk("ack", pixel_ack, exp_ack);
          if (g >= 0) begin
            mdata[16*mcount +: 16] = {4'h0, pixel[12*g +: 12]};
            mcount++;
            mrr   = (g + 1) % N;
            pop_g = g;
            n_ack++;
          end
          if (mcount == SLOTS || (fa && mcount > 0)) begin
            sbq.push_back('{addr: maddr, data: mdata, fl: fa});
            mst = M_WRITE; m_en = 1'b1; m_wren = 1'b1;
          end else if (fa) begin
            mst = M_FACK;
          end
        end
        M_WRITE: begin
          chk("ack_in_write", pixel_ack, '0);
          chk("app_cmd", app_cmd, 3'b000);
          if (sbq.size() > 0) begin
            chk("wdata", app_wdf_data, sbq[0].data);
            chk("waddr", app_addr, sbq[0].addr);
          end
          if (m_en && app_rdy) m_en = 1'b0;
          if (m_wren && app_wdf_rdy) m_wren = 1'b0;
          if (!m_en && !m_wren && sbq.size() > 0) begin
            e          = sbq.pop_front();
            last_wdata = app_wdf_data;
            last_waddr = app_addr;
            mwords++;
            mcount = 0;
            mdata  = '0;
            if (maddr == END_A) begin
              maddr = '0; mwrapped = 1'b1;
            end else begin
              maddr = maddr + 27'd8;
            end
            mst = e.fl ? M_FACK : M_FILL;
          end
        end
        default: begin
          chk("ack_in_flush_ack", pixel_ack, '0);
          mst = M_FILL;
        end
      endcase
      mlat = (prev == M_FACK) ? flush : (mlat | flush);
    end
  end

  task automatic wait_words(input int unsigned tgt);
    int i = 0;
    while (words_written < tgt && i < 400) begin
      @(negedge dram_clk);
      i++;
    end
    chk("words_reached", words_written, tgt);
  endtask

  task automatic wait_hi(input int sel);
    int i = 0;
    while (!(sel == 0 ? app_en : app_wdf_wren) && i < 400) begin
      @(negedge dram_clk);
      i++;
    end
    chk(sel == 0 ? "app_en_rise" : "wren_rise", sel == 0 ? app_en : app_wdf_wren, 1'b1);
  endtask

  task automatic wait_fd(input int tgt);
    int i = 0;
    while (fd_cnt < tgt && i < 400) begin
      @(negedge dram_clk);
      i++;
    end
    chk("flush_done_count", fd_cnt, tgt);
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(negedge dram_clk);
    flush = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] w;
    int            fd0;
    int unsigned   w0;
    reset_n = 1'b0; flush = 1'b0; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    n_ack = 0; en_cycles = 0; wren_cycles = 0; fd_cnt = 0;
    last_wdata = '0; last_waddr = '0;
    repeat (3) @(negedge dram_clk);
    chk("rst_app_addr", app_addr, 27'h0);
    chk("rst_app_en", app_en, 1'b0);
    chk("rst_wren", app_wdf_wren, 1'b0);
    chk("rst_wdata", app_wdf_data, '0);
    chk("rst_words", words_written, 0);
    chk("rst_flush_done", flush_done, 1'b0);
    reset_n = 1'b1;
    @(negedge dram_clk);

    // Single matcher, one full word
    n_ack = 0; en_cycles = 0;
    for (int k = 1; k <= SLOTS; k++) mq[0].push_back(12'(k));
    wait_words(1);
    repeat (2) @(negedge dram_clk);
    chk("t1_acks", n_ack, 16);
    chk("t1_en_cycles", en_cycles, 1);
    w = '0;
    for (int k = 0; k < SLOTS; k++) w[16*k +: 16] = 16'(k + 1);
    chk("t1_word", last_wdata, w);
    chk("t1_addr", last_waddr, 27'h0);

    // All matchers pending: round robin, crosses the address wrap
    for (int i = 0; i < N; i++)
      for (int k = 0; k < SLOTS; k++) mq[i].push_back(12'(i * 256 + k));
    wait_words(5);
    repeat (2) @(negedge dram_clk);
    chk("t2_last_addr", last_waddr, END_A);
    chk("t2_wrapped", wrapped, 1'b1);
    chk("t2_addr_after_wrap", app_addr, 27'h0);

    // Write data held off for 5 cycles
    app_wdf_rdy = 1'b0; en_cycles = 0; wren_cycles = 0;
    for (int k = 0; k < SLOTS; k++) mq[1].push_back(12'h500 + 12'(k));
    wait_hi(1);
    repeat (5) @(negedge dram_clk);
    app_wdf_rdy = 1'b1;
    wait_words(6);
    repeat (2) @(negedge dram_clk);
    chk("t3_en_cycles", en_cycles, 1);
    chk("t3_wren_cycles", wren_cycles, 6);

    // Flush after 3 pixels
    fd0 = fd_cnt;
    for (int k = 0; k < 3; k++) mq[2].push_back(12'ha01 + 12'(k));
    repeat (6) @(negedge dram_clk);
    pulse_flush();
    wait_words(7);
    wait_fd(fd0 + 1);
    w = '0;
    w[47:0] = 48'h0a03_0a02_0a01;
    chk("t4_word", last_wdata, w);
    chk("t4_addr", last_waddr, 27'h8);

    // Flush with an empty buffer
    fd0 = fd_cnt; w0 = words_written;
    pulse_flush();
    repeat (3) @(negedge dram_clk);
    chk("t5_flush_done", fd_cnt, fd0 + 1);
    chk("t5_no_write", words_written, w0);

    // Flush arriving during a write is latched
    fd0 = fd_cnt;
    app_rdy = 1'b0;
    for (int k = 0; k < SLOTS; k++) mq[3].push_back(12'h7c0 + 12'(k));
    wait_hi(0);
    pulse_flush();
    repeat (2) @(negedge dram_clk);
    app_rdy = 1'b1;
    wait_words(8);
    wait_fd(fd0 + 1);
    repeat (4) @(negedge dram_clk);
    chk("t6_no_extra_write", words_written, 8);

    // Reset in the middle of a write
    app_rdy = 1'b0;
    for (int k = 0; k < SLOTS; k++) mq[0].push_back(12'h300 + 12'(k));
    wait_hi(0);
    reset_n = 1'b0;
    for (int i = 0; i < N; i++) mq[i].delete();
    #1;
    chk("t7_rst_app_en", app_en, 1'b0);
    chk("t7_rst_wren", app_wdf_wren, 1'b0);
    chk("t7_rst_words", words_written, 0);
    chk("t7_rst_addr", app_addr, 27'h0);
    repeat (2) @(negedge dram_clk);
    reset_n = 1'b1;
    app_rdy = 1'b1;
    for (int k = 0; k < SLOTS; k++) mq[1].push_back(12'h0f0 + 12'(k));
    wait_words(1);
    repeat (2) @(negedge dram_clk);
    chk("t7_post_addr", last_waddr, 27'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
